fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// - Instruction-fetch stage of the 5-stage pipelined MIPS: owns PCF, the IF/ID register and the instruction-memory request port.
// - Sits at the receiving end of the hazard unit's stall/flush signalling: honours StallF/StallD and the decode-stage redirect (PCSrcD, JumpD).
// - Raises FetchStallF while imem has not returned the current word; the top level ORs it into the front-end stall.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PCF value after reset
// - NOP_INSTR 32'h0000_0000  InstrD value after reset and on flush/bubble (sll $0,$0,0)
// PORTS
// - clk         in   1   clock, all state updates on rising edge
// - rst         in   1   asynchronous, active-high reset
// - StallF      in   1   hazard unit: hold PCF, issue no new request
// - StallD      in   1   hazard unit: hold IF/ID contents
// - PCSrcD      in   1   branch taken in decode
// - PCBranchD   in   32  branch target
// - JumpD       in   1   jump in decode
// - PCJumpD     in   32  jump target
// - ImemReq     out  1   fetch request, held high until ImemValid
// - ImemAddr    out  32  fetch address (=PCF), stable while ImemReq=1
// - ImemRdata   in   32  instruction word, qualified by ImemValid
// - ImemValid   in   1   response strobe; may be high in first ImemReq cycle (zero-wait)
// - InstrD      out  32  IF/ID instruction
// - PCPlus4D    out  32  IF/ID PC+4
// - ValidD      out  1   IF/ID holds a real instruction (0 = bubble)
// - FetchStallF out  1   fetch waiting on imem
// BEHAVIOUR
// - Reset (async): PCF=RESET_PC, state=IDLE, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, ImemReq=0, kill=0, redir_pend=0, buffer empty.
// - States: IDLE (one cycle after reset release, ImemReq=0) -> WAIT.
//   WAIT: ImemReq=1, ImemAddr=PCF. HELD: word received, held in buffer because StallD=1, ImemReq=0.
// - "Word available" = (WAIT & ImemValid & !kill) | HELD.
// - Redirect accepted only when StallD=0 and (PCSrcD|JumpD); PCSrcD has priority over JumpD if both set.
// - Redirect accepted: IF/ID <= bubble (InstrD=NOP_INSTR, ValidD=0, PCPlus4D=0); any available word dropped, buffer cleared.
//   If a request is in flight without ImemValid this cycle: kill<=1, target saved in redir_pc, redir_pend<=1, PCF unchanged (address stability).
//   Otherwise PCF<=target and state->WAIT next cycle.
// - WAIT & ImemValid & kill: response discarded, kill<=0, PCF<=redir_pc, redir_pend<=0, stay WAIT (new request next cycle).
// - No redirect, word available, StallD=0: InstrD<=word, PCPlus4D<=PCF+4, ValidD<=1; PCF<=PCF+4 unless StallF; state->WAIT.
//   Back-to-back zero-wait imem gives 1 instr/cycle.
// - Word available, StallD=1: IF/ID unchanged; WAIT->HELD capturing ImemRdata; HELD stays HELD; PCF unchanged.
// - No word available, StallD=0: IF/ID <= bubble; StallD=1: IF/ID unchanged.
// - StallF=1 with StallD=0 (not produced by hazard unit): PCF held, word still transferred once; no duplicate fetch issued.
// - FetchStallF = (state==WAIT) & (!ImemValid | kill) | (state==IDLE). Combinational.
// - PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000; bits[1:0] of targets passed through unchecked.
// - Reset asserted mid-request: ImemReq drops immediately; imem must discard the outstanding response.
// TESTING
// - Reset, zero-wait imem returns addr-derived word -> ImemAddr 0,4,8,... each cycle from 2nd cycle; InstrD follows 1 cycle later, ValidD=1.
// - Imem latency 3 at PCF=0x40 -> FetchStallF=1 for 2 cycles, ImemAddr stable 0x40, ValidD=0 bubbles, then InstrD=word, PCPlus4D=0x44.
// - StallD=StallF=1 for 3 cycles as word for 0x10 arrives -> state HELD, IF/ID frozen, ImemReq=0; on release InstrD=word(0x10), next ImemAddr=0x14.
// - PCSrcD=1, PCBranchD=0x200 with zero-wait imem -> next IF/ID bubble, next ImemAddr=0x200, word from old PC never reaches InstrD.
// - JumpD=1 to 0x300 while 4-cycle request in flight -> ImemAddr held until ImemValid, response dropped, then ImemAddr=0x300.
// - PCSrcD=1 with StallD=1 -> redirect ignored, PCF unchanged; redirect taken in first cycle StallD=0; rst pulse mid-WAIT -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF, the IF/ID register and the imem request port.
// Honours hazard-unit stalls, decode redirects and a variable-latency instruction memory.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemValid,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchStallF
);

    // S_DONE: word handed to decode under StallF, PCF not yet advanced, no request outstanding.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        kill_q, kill_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_q, buf_d;

    logic        in_wait_s;
    logic        word_avail_s;
    logic [31:0] word_s;
    logic        redir_take_s;
    logic [31:0] redir_tgt_s;
    logic        in_flight_s;
    logic [31:0] pc_plus4_s;

    assign in_wait_s    = (state_q == S_WAIT);
    assign word_avail_s = (in_wait_s & ImemValid & ~kill_q) | (state_q == S_HELD);
    assign word_s       = (state_q == S_HELD) ? buf_q : ImemRdata;
    assign redir_take_s = ~StallD & (PCSrcD | JumpD);
    assign redir_tgt_s  = PCSrcD ? PCBranchD : PCJumpD;
    assign in_flight_s  = in_wait_s & ~ImemValid;
    assign pc_plus4_s   = pcf_q + 32'd4;

    // Next-state for PC, fetch FSM, kill tracking and IF/ID.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        buf_d        = buf_q;

        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (kill_q && ImemValid) begin
                    kill_d       = 1'b0;
                    redir_pend_d = 1'b0;
                    pcf_d        = redir_pc_q;
                end else begin
                    kill_d = kill_q;
                end
            end
            S_HELD:  state_d = S_HELD;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (redir_take_s) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
            // Address must stay stable while the old request is outstanding.
            if (in_flight_s) begin
                kill_d       = 1'b1;
                redir_pc_d   = redir_tgt_s;
                redir_pend_d = 1'b1;
            end else begin
                pcf_d        = redir_tgt_s;
                state_d      = S_WAIT;
                kill_d       = 1'b0;
                redir_pend_d = 1'b0;
            end
        end else if (word_avail_s) begin
            if (!StallD) begin
                instr_d = word_s;
                pc4_d   = pc_plus4_s;
                valid_d = 1'b1;
                if (StallF) begin
                    state_d = S_DONE;
                end else begin
                    pcf_d   = pc_plus4_s;
                    state_d = S_WAIT;
                end
            end else if (in_wait_s) begin
                state_d = S_HELD;
                buf_d   = ImemRdata;
            end else begin
                state_d = S_HELD;
            end
        end else begin
            if ((state_q == S_DONE) && !StallF) begin
                pcf_d   = pc_plus4_s;
                state_d = S_WAIT;
            end else begin
                pcf_d = pcf_d;
            end
            if (!StallD) begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pcf_q        <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0000_0000;
            valid_q      <= 1'b0;
            kill_q       <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
            buf_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            buf_q        <= buf_d;
        end
    end

    assign ImemReq     = in_wait_s;
    assign ImemAddr    = pcf_q;
    assign InstrD      = instr_q;
    assign PCPlus4D    = pc4_q;
    assign ValidD      = valid_q;
    assign FetchStallF = (in_wait_s & (~ImemValid | kill_q)) | (state_q == S_IDLE);

endmodule
